mux_sel_pipe: RTL and testbench

//  Parametrised N-to-1 select with a registered, flow-controlled output stage.

---
 rtl/mux_sel_pkg.sv | 16 +
 rtl/mux_sel_skid.sv | 71 +++++++
 rtl/mux_sel_pipe.sv | 63 ++++++
 tb/tb_mux_sel_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the parametrised select pipe.
// mux_item_t is the default-width payload; the top derives its own width-matched copy.
package mux_sel_pkg;

   localparam int unsigned MUX_DATA_W = 32;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [MUX_DATA_W-1:0] data;
      logic                  sel_err;
   } mux_item_t;

endpackage

// File: rtl/mux_sel_skid.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
// in_ready depends only on the skid register, never on out_ready.
module mux_sel_skid #(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         accept;
   logic         drain;

   assign accept = in_valid & ~skid_valid_q & ~flush;
   assign drain  = ~out_valid_q | out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain) begin
         // A full skid blocks in_ready, so no accept can coincide with the skid move.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_data_d = in_data;
            end
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/mux_sel_pipe.sv
// Parametrised N:1 select with range check, feeding a registered, stallable skid stage.
module mux_sel_pipe
   import mux_sel_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_IN   = 8,
   parameter int unsigned SEL_W    = sel_width(NUM_IN),
   parameter int          ERR_ZERO = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_IN*DATA_W-1:0] data_in,
   input  logic [SEL_W-1:0]         sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_sel_err
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sel_err;
   } item_t;

   item_t sel_item;
   item_t out_item;

   always_comb begin
      sel_item.sel_err = 1'b1;
      if (ERR_ZERO != 0) begin
         sel_item.data = '0;
      end else begin
         sel_item.data = data_in[(NUM_IN-1)*DATA_W +: DATA_W];
      end
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_item.data    = data_in[k*DATA_W +: DATA_W];
            sel_item.sel_err = 1'b0;
         end
      end
   end

   mux_sel_skid #(
      .W($bits(item_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (sel_item),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_item)
   );

   assign out_data    = out_item.data;
   assign out_sel_err = out_item.sel_err;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench: three select pipes (8 inputs; 5 inputs zero-on-error; 5 inputs last-input-on-error)
// share one stimulus stream and are compared every cycle with a queue-based model.
module tb_mux_sel_pipe;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            out_ready;
   logic [8*DW-1:0] data_in;
   logic [2:0]      sel;

   logic          r8, v8, e8, r5z, v5z, e5z, r5n, v5n, e5n;
   logic [DW-1:0] d8, d5z, d5n;

   int checks = 0;
   int errors = 0;

   mux_sel_pipe #(.DATA_W(DW), .NUM_IN(8), .ERR_ZERO(1)) u8 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r8),
      .data_in(data_in), .sel(sel), .out_valid(v8), .out_ready(out_ready),
      .out_data(d8), .out_sel_err(e8));

   mux_sel_pipe #(.DATA_W(DW), .NUM_IN(5), .ERR_ZERO(1)) u5z (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r5z),
      .data_in(data_in[5*DW-1:0]), .sel(sel), .out_valid(v5z), .out_ready(out_ready),
      .out_data(d5z), .out_sel_err(e5z));

   mux_sel_pipe #(.DATA_W(DW), .NUM_IN(5), .ERR_ZERO(0)) u5n (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r5n),
      .data_in(data_in[5*DW-1:0]), .sel(sel), .out_valid(v5n), .out_ready(out_ready),
      .out_data(d5n), .out_sel_err(e5n));

   typedef struct {
      logic [DW-1:0] d8, d5z, d5n;
      logic          e8, e5z, e5n;
   } exp_t;

   exp_t q[$];

   function automatic exp_t mk(input logic [2:0] s, input logic [8*DW-1:0] din);
      exp_t        e;
      int unsigned i;
      i = int'(s);
      e.d8 = din[i*DW +: DW];
      e.e8 = 1'b0;
      if (i < 5) begin
         e.d5z = din[i*DW +: DW];
         e.d5n = din[i*DW +: DW];
         e.e5z = 1'b0;
         e.e5n = 1'b0;
      end else begin
         e.d5z = '0;
         e.d5n = din[4*DW +: DW];
         e.e5z = 1'b1;
         e.e5n = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the block is a FIFO of capacity two; front of the queue is out_data.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else if (in_valid && q.size() < 2) begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         q.push_back(mk(sel, data_in));
      end else if (q.size() > 0 && out_ready) begin
         void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("in_ready8",  64'(r8),  64'(q.size() < 2));
         chk("in_ready5z", 64'(r5z), 64'(q.size() < 2));
         chk("in_ready5n", 64'(r5n), 64'(q.size() < 2));
         chk("out_valid8",  64'(v8),  64'(q.size() > 0));
         chk("out_valid5z", 64'(v5z), 64'(q.size() > 0));
         chk("out_valid5n", 64'(v5n), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("data8",  64'(d8),  64'(q[0].d8));
            chk("err8",   64'(e8),  64'(q[0].e8));
            chk("data5z", 64'(d5z), 64'(q[0].d5z));
            chk("err5z",  64'(e5z), 64'(q[0].e5z));
            chk("data5n", 64'(d5n), 64'(q[0].d5n));
            chk("err5n",  64'(e5n), 64'(q[0].e5n));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      for (int k = 0; k < 8; k++) data_in[k*DW +: DW] = $urandom;
   endtask

   logic [DW-1:0] a, b, c, held, s4, s6;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sel = '0; data_in = '0;
      #23;
      chk("rst_out_valid", 64'(v8), 64'd0);
      chk("rst_in_ready",  64'(r8), 64'd1);
      chk("rst_out_data",  64'(d8), 64'd0);
      chk("rst_sel_err",   64'(e8), 64'd0);
      rst_n = 1'b1;

      // single item with sel=3
      rand_data();
      data_in[3*DW +: DW] = 32'hDEAD_BEEF;
      sel = 3'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_valid", 64'(v8), 64'd1);
      chk("t1_data",  64'(d8), 64'h0000_0000_DEAD_BEEF);
      chk("t1_err",   64'(e8), 64'd0);
      step();

      // back-to-back stream sel 0..7
      for (int i = 0; i < 8; i++) begin
         rand_data();
         sel = 3'(i); in_valid = 1'b1;
         step();
         chk("t2_in_ready", 64'(r8), 64'd1);
      end
      in_valid = 1'b0;
      step();

      // stall: A held, B in skid, C refused until release
      out_ready = 1'b0; sel = 3'd2;
      rand_data(); a = data_in[2*DW +: DW]; in_valid = 1'b1;
      step();
      rand_data(); b = data_in[2*DW +: DW];
      step();
      rand_data(); c = data_in[2*DW +: DW];
      step();
      chk("t3_hold_a",  64'(d8), 64'(a));
      chk("t3_in_rdy0", 64'(r8), 64'd0);
      out_ready = 1'b1;
      step();
      chk("t3_out_b", 64'(d8), 64'(b));
      chk("t3_in_rdy1", 64'(r8), 64'd1);
      step();
      chk("t3_out_c", 64'(d8), 64'(c));
      in_valid = 1'b0;
      step();
      chk("t3_empty", 64'(v8), 64'd0);

      // out-of-range select on the 5-input instances
      rand_data(); sel = 3'd6; in_valid = 1'b1;
      s4 = data_in[4*DW +: DW]; s6 = data_in[6*DW +: DW];
      step();
      in_valid = 1'b0;
      chk("t4_zero_data", 64'(d5z), 64'd0);
      chk("t4_zero_err",  64'(e5z), 64'd1);
      chk("t4_last_data", 64'(d5n), 64'(s4));
      chk("t4_last_err",  64'(e5n), 64'd1);
      chk("t4_n8_data",   64'(d8),  64'(s6));
      chk("t4_n8_err",    64'(e8),  64'd0);
      step();

      // flush with both entries full and a new item offered
      out_ready = 1'b0; sel = 3'd1; in_valid = 1'b1;
      rand_data(); step();
      rand_data(); step();
      chk("t5_full", 64'(r8), 64'd0);
      held = d8;
      flush = 1'b1; rand_data();
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_valid0",  64'(v8), 64'd0);
      chk("t5_ready1",  64'(r8), 64'd1);
      chk("t5_data_kept", 64'(d8), 64'(held));
      out_ready = 1'b1;
      step();
      chk("t5_no_emit", 64'(v8), 64'd0);

      // asynchronous reset pulse mid-stream
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_data(); sel = 3'($urandom); step();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid0", 64'(v8),  64'd0);
      chk("t6_v5z0",   64'(v5z), 64'd0);
      chk("t6_data0",  64'(d8),  64'd0);
      chk("t6_ready1", 64'(r8),  64'd1);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      step(); step();

      // randomized traffic with occasional flush
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         sel       = 3'($urandom);
         rand_data();
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
